// File: rtl/wb_master_cmd.sv
// Single-beat Wishbone classic-cycle initiator fed by a valid/ready command stream.
// Optional cycle timeout is compiled in with `define WB_MASTER_CMD_TIMEOUT_EN.
module wb_master_cmd #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic                    cmd_we,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    we_o,
  output logic [SELECT_WIDTH-1:0] sel_o,
  output logic                    stb_o,
  input  logic                    ack_i,
  input  logic                    err_i,
  output logic                    cyc_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t                  r_state, w_state_nx;
  logic                    r_cmd_ready, w_cmd_ready_nx;
  logic [DATA_WIDTH-1:0]   r_rsp_data, w_rsp_data_nx;
  logic                    r_rsp_err, w_rsp_err_nx;
  logic                    r_rsp_valid, w_rsp_valid_nx;
  logic [ADDR_WIDTH-1:0]   r_adr, w_adr_nx;
  logic [DATA_WIDTH-1:0]   r_dat, w_dat_nx;
  logic                    r_we, w_we_nx;
  logic [SELECT_WIDTH-1:0] r_sel, w_sel_nx;
  logic                    r_cyc, w_cyc_nx;
  logic                    w_term;

`ifdef WB_MASTER_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nx;
  logic          r_rsp_timeout, w_rsp_timeout_nx;
  logic          w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_cmd_ready_nx = r_cmd_ready;
    w_rsp_data_nx  = r_rsp_data;
    w_rsp_err_nx   = r_rsp_err;
    w_rsp_valid_nx = r_rsp_valid;
    w_adr_nx       = r_adr;
    w_dat_nx       = r_dat;
    w_we_nx        = r_we;
    w_sel_nx       = r_sel;
    w_cyc_nx       = r_cyc;
    w_term         = 1'b0;
`ifdef WB_MASTER_CMD_TIMEOUT_EN
    w_tmo_cnt_nx     = r_tmo_cnt;
    w_rsp_timeout_nx = r_rsp_timeout;
`endif
    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nx = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_adr_nx       = cmd_addr;
          w_dat_nx       = cmd_data;
          w_we_nx        = cmd_we;
          w_sel_nx       = cmd_sel;
          w_cyc_nx       = 1'b1;
          w_cmd_ready_nx = 1'b0;
          w_state_nx     = S_BUS;
`ifdef WB_MASTER_CMD_TIMEOUT_EN
          w_tmo_cnt_nx   = '0;
`endif
        end
      end
      S_BUS: begin
        // err_i outranks ack_i, and both outrank an expiring timeout
        if (err_i) begin
          w_term        = 1'b1;
          w_rsp_err_nx  = 1'b1;
          w_rsp_data_nx = '0;
        end else if (ack_i) begin
          w_term        = 1'b1;
          w_rsp_err_nx  = 1'b0;
          w_rsp_data_nx = r_we ? '0 : dat_i;
        end
`ifdef WB_MASTER_CMD_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_term        = 1'b1;
          w_rsp_err_nx  = 1'b1;
          w_rsp_data_nx = '0;
        end else begin
          w_tmo_cnt_nx  = r_tmo_cnt + TW'(1);
        end
        if (w_term) w_rsp_timeout_nx = !(err_i || ack_i);
`endif
        if (w_term) begin
          w_cyc_nx       = 1'b0;
          w_rsp_valid_nx = 1'b1;
          w_state_nx     = S_RESP;
        end
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid_nx = 1'b0;
          w_cmd_ready_nx = 1'b1;
          w_state_nx     = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_cyc       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cmd_ready <= w_cmd_ready_nx;
      r_rsp_data  <= w_rsp_data_nx;
      r_rsp_err   <= w_rsp_err_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_adr       <= w_adr_nx;
      r_dat       <= w_dat_nx;
      r_we        <= w_we_nx;
      r_sel       <= w_sel_nx;
      r_cyc       <= w_cyc_nx;
    end
  end

`ifdef WB_MASTER_CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt     <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_tmo_cnt     <= w_tmo_cnt_nx;
      r_rsp_timeout <= w_rsp_timeout_nx;
    end
  end
  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = r_cmd_ready;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign rsp_valid = r_rsp_valid;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign we_o      = r_we;
  assign sel_o     = r_sel;
  assign cyc_o     = r_cyc;
  assign stb_o     = r_cyc;

endmodule

// File: tb/tb_wb_master_cmd.sv
// Randomized bench for wb_master_cmd against a word-memory scoreboard and a scripted responder.
// Honours WB_MASTER_CMD_TIMEOUT_EN to select the expected timeout behaviour.
module tb_wb_master_cmd;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, rsp_timeout, rsp_valid;
  logic        rsp_ready;
  logic [15:0] adr_o;
  logic [31:0] dat_i, dat_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o, ack_i, err_i, cyc_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] ram     [16];  // responder storage, addressed by the bus
  logic [31:0] exp_mem [16];  // scoreboard, addressed by the command stream

  wb_master_cmd #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .adr_o(adr_o), .dat_i(dat_i), .dat_o(dat_o), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i), .cyc_o(cyc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset for one edge while a cycle is in flight, then checks recovery.
  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cyc_stb", {cyc_o, stb_o}, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cmd_ready_low", cmd_ready, 1'b0);
    tick();
    chk("rst_cmd_ready_up", cmd_ready, 1'b1);
    chk("rst_no_rsp", rsp_valid, 1'b0);
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 no answer, 4 reset after one bus cycle
  task automatic do_txn(input logic [15:0] addr, input logic [31:0] data, input logic we,
                        input logic [3:0] sel, input int unsigned d, input int mode,
                        input int unsigned hold);
    int unsigned n, cnt, idx, exp_cyc;
    logic        exp_err, exp_tmo, saw_valid;
    logic [31:0] exp_data;
    idx = 32'(addr[5:2]);
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_addr = addr; cmd_data = data; cmd_we = we; cmd_sel = sel; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_addr = 16'($urandom); cmd_data = $urandom; cmd_we = 1'($urandom); cmd_sel = 4'($urandom);
    chk("bus_out", {cyc_o, stb_o, we_o, sel_o, adr_o, cmd_ready}, {2'b11, we, sel, addr, 1'b0});
    chk("bus_dat", dat_o, data);
    cnt = 1;

    if (mode == 4) begin
      tick();
      reset_pulse();
      return;
    end

    if (mode == 3) begin
`ifdef WB_MASTER_CMD_TIMEOUT_EN
      n = 0;
      while (n < 40) begin
        tick();
        if (!cyc_o) break;
        cnt++; n++;
      end
      chk("tmo_cyc_len", cnt, TMO);
      exp_err = 1'b1; exp_tmo = 1'b1; exp_data = '0;
`else
      saw_valid = 1'b0;
      repeat (120) begin
        tick();
        if (rsp_valid) saw_valid = 1'b1;
        cnt += 32'(cyc_o);
      end
      chk("notmo_cyc_len", cnt, 121);
      chk("notmo_no_rsp", saw_valid, 1'b0);
      reset_pulse();
      return;
`endif
    end else begin
      repeat (d) begin
        tick();
        cnt += 32'(cyc_o);
      end
      ack_i = (mode != 1);
      err_i = (mode != 0);
      if (!we) dat_i = ram[idx];
      @(posedge clk);
      if (mode == 0 && we_o) ram[adr_o[5:2]] = merge(ram[adr_o[5:2]], dat_o, sel_o);
      #1;
      ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
      exp_cyc  = d + 1;
      exp_err  = (mode != 0);
      exp_tmo  = 1'b0;
      exp_data = (mode == 0 && !we) ? exp_mem[idx] : 32'h0;
      chk("cyc_len", cnt, exp_cyc);
    end

    if (we && mode == 0) exp_mem[idx] = merge(exp_mem[idx], data, sel);
    chk("term_cyc", {cyc_o, stb_o}, 2'b00);
    chk("rsp", {rsp_valid, rsp_err, rsp_timeout, cmd_ready}, {1'b1, exp_err, exp_tmo, 1'b0});
    chk("rsp_data", rsp_data, exp_data);

    // A pending command during back-pressure must wait for the handshake to complete.
    cmd_valid = 1'b1;
    repeat (hold) begin
      tick();
      chk("bp_hold", {rsp_valid, rsp_err, rsp_timeout, cmd_ready, cyc_o, rsp_data},
          {1'b1, exp_err, exp_tmo, 1'b0, 1'b0, exp_data});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("handshake", {rsp_valid, cmd_ready, cyc_o}, 3'b010);
  endtask

  initial begin
    logic [31:0] wd;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_we = 1'b0; cmd_sel = '0;
    rsp_ready = 1'b0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    for (int i = 0; i < 16; i++) begin ram[i] = '0; exp_mem[i] = '0; end
    repeat (3) tick();
    chk("reset_bus", {cyc_o, stb_o, we_o, sel_o, adr_o}, '0);
    chk("reset_dat", dat_o, 32'h0);
    chk("reset_rsp", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_data}, '0);
    rst = 1'b0;
    chk("reset_cmd_ready_low", cmd_ready, 1'b0);
    tick();
    chk("reset_cmd_ready_up", cmd_ready, 1'b1);

    do_txn(16'h0010, 32'hDEADBEEF, 1'b1, 4'hF, 1, 0, 0);
    do_txn(16'h0010, 32'h0,        1'b0, 4'hF, 1, 0, 0);
    do_txn(16'h0020, 32'h11223344, 1'b1, 4'hF, 1, 0, 0);
    do_txn(16'h0020, 32'hAA000000, 1'b1, 4'h8, 1, 0, 0);
    do_txn(16'h0020, 32'h0,        1'b0, 4'hF, 1, 0, 0);
    chk("bytesel_model", exp_mem[8], 32'hAA223344);
    do_txn(16'h0010, 32'h0,        1'b0, 4'hF, 1, 2, 0);
    do_txn(16'h0010, 32'h12345678, 1'b1, 4'hF, 0, 1, 0);
    do_txn(16'h0010, 32'h0,        1'b0, 4'hF, 0, 0, 10);
    do_txn(16'h0030, 32'hCAFEF00D, 1'b1, 4'hF, 2, 3, 0);
`ifdef WB_MASTER_CMD_TIMEOUT_EN
    do_txn(16'h0030, 32'h0,        1'b0, 4'hF, TMO - 1, 0, 0);
    do_txn(16'h0030, 32'h0,        1'b0, 4'hF, TMO - 1, 1, 0);
`endif
    do_txn(16'h0014, 32'h55AA55AA, 1'b1, 4'hF, 1, 4, 0);
    do_txn(16'h0014, 32'h0,        1'b0, 4'hF, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      wd = $urandom;
      do_txn({8'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 15)), 2'b00}, wd,
             1'($urandom), 4'($urandom), $urandom_range(0, 4),
             ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2)),
             $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
